// File: rtl/vga_text_pkg.sv
// Shared types for the text-overlay path: placement record, blank placement and sequencer states.
package vga_text_pkg;

  typedef struct packed {
    logic [7:0]  chr;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] fg;
    logic [23:0] bg;
  } placement_t;

  // Off-screen box so the pixel generator never matches while blanked.
  localparam placement_t BlankPlacement = '{
    chr: 8'h00, x: 12'hFFF, y: 12'hFFF, fg: 24'h000000, bg: 24'h000000
  };

  typedef enum logic [0:0] {StBlank, StShow} state_e;

endpackage

// File: rtl/placement_fifo.sv
// Synchronous FIFO of placement records with a separate occupancy counter.
module placement_fifo
  import vga_text_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  placement_t      data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output placement_t      head_o,
  output logic [CntW-1:0] count_o
);

  placement_t      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign do_push = push_i && (count_q != CntW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/char_placement_ctrl.sv
// Frame-synchronous placement sequencer: queues host commands and commits one per
// vertical-blank boundary, holding each for a programmable number of frames.
module char_placement_ctrl
  import vga_text_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned DWELL_W  = 8
) (
  input  logic                   pix_clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_char,
  input  logic [11:0]            cmd_x,
  input  logic [11:0]            cmd_y,
  input  logic [23:0]            cmd_fg,
  input  logic [23:0]            cmd_bg,
  input  logic [DWELL_W-1:0]     dwell_frames,
  input  logic                   clear,
  input  logic [11:0]            pix_x,
  input  logic [11:0]            pix_y,
  output logic [7:0]             character,
  output logic [11:0]            char_x,
  output logic [11:0]            char_y,
  output logic [23:0]            char_color,
  output logic [23:0]            background_color,
  output logic                   frame_update,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  state_e             state_q;
  placement_t         place_q, head, cmd;
  logic [DWELL_W-1:0] dwell_q, dwell_init;
  logic               flush_pending_q, update_q;
  logic               bnd, push, flush, load;

  assign cmd = {cmd_char, cmd_x, cmd_y, cmd_fg, cmd_bg};
  assign bnd = (pix_x == 12'd0) && (pix_y == 12'(V_ACTIVE));

  assign cmd_ready = (fifo_count != CntW'(DEPTH)) && !flush_pending_q;
  assign push      = cmd_valid && cmd_ready;

  // A pending flush wins the boundary; otherwise pop once the dwell has expired.
  assign flush = bnd && flush_pending_q;
  assign load  = bnd && !flush_pending_q && (fifo_count != '0) &&
                 ((state_q == StBlank) || (dwell_q == '0));

  assign dwell_init = (dwell_frames == '0) ? '0 : dwell_frames - 1'b1;

  placement_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (pix_clk),
    .rst_ni (rst_n),
    .push_i (push),
    .data_i (cmd),
    .pop_i  (load),
    .flush_i(flush),
    .head_o (head),
    .count_o(fifo_count)
  );

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StBlank;
      place_q         <= BlankPlacement;
      dwell_q         <= '0;
      update_q        <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      update_q <= 1'b0;
      if (flush) begin
        state_q         <= StBlank;
        place_q         <= BlankPlacement;
        dwell_q         <= '0;
        update_q        <= 1'b1;
        flush_pending_q <= 1'b0;
      end else if (load) begin
        state_q  <= StShow;
        place_q  <= head;
        dwell_q  <= dwell_init;
        update_q <= 1'b1;
      end else if (bnd && (state_q == StShow) && (dwell_q != '0)) begin
        dwell_q <= dwell_q - 1'b1;
      end
      // A clear on the flushing boundary re-arms for the next one.
      if (clear) flush_pending_q <= 1'b1;
    end
  end

  assign character        = place_q.chr;
  assign char_x           = place_q.x;
  assign char_y           = place_q.y;
  assign char_color       = place_q.fg;
  assign background_color = place_q.bg;
  assign frame_update     = update_q;

endmodule

// File: tb/tb_char_placement_ctrl.sv
// Self-checking bench for char_placement_ctrl: directed sequences, a dwell table and a
// placement scoreboard fed on accepted pushes and drained on each frame_update.
module tb_char_placement_ctrl;
  import vga_text_pkg::*;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned DWELL_W  = 8;

  logic        pix_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_char = '0;
  logic [11:0] cmd_x = '0, cmd_y = '0;
  logic [23:0] cmd_fg = '0, cmd_bg = '0;
  logic [DWELL_W-1:0] dwell_frames = 8'd1;
  logic        clear = 1'b0;
  logic [11:0] pix_x = 12'd100, pix_y = 12'd10;
  logic [7:0]  character;
  logic [11:0] char_x, char_y;
  logic [23:0] char_color, background_color;
  logic        frame_update;
  logic [$clog2(DEPTH):0] fifo_count;

  char_placement_ctrl #(
    .DEPTH   (DEPTH),
    .V_ACTIVE(V_ACTIVE),
    .DWELL_W (DWELL_W)
  ) dut (
    .pix_clk         (pix_clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_char        (cmd_char),
    .cmd_x           (cmd_x),
    .cmd_y           (cmd_y),
    .cmd_fg          (cmd_fg),
    .cmd_bg          (cmd_bg),
    .dwell_frames    (dwell_frames),
    .clear           (clear),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .character       (character),
    .char_x          (char_x),
    .char_y          (char_y),
    .char_color      (char_color),
    .background_color(background_color),
    .frame_update    (frame_update),
    .fifo_count      (fifo_count)
  );

  always #5 pix_clk = ~pix_clk;

  placement_t cur;
  assign cur = {character, char_x, char_y, char_color, background_color};

  int n_checks = 0;
  int n_errors = 0;
  placement_t exp_q[$];

  typedef struct {
    placement_t p;
    logic [7:0] dwell;
    int         frames;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic placement_t mk(input int i);
    placement_t p;
    p.chr = 8'(8'h50 + i);
    p.x   = 12'(16 * i);
    p.y   = 12'(8 * i + 1);
    p.fg  = 24'(i * 24'h010203);
    p.bg  = ~p.fg;
    return p;
  endfunction

  // Advance one clock and sample 1 time unit after the edge; drain the scoreboard on loads.
  task automatic tick();
    placement_t e;
    @(posedge pix_clk);
    #1;
    if (frame_update && (cur != BlankPlacement)) begin
      check("sb_nonempty", 80'(exp_q.size() != 0), 80'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_placement", cur, e);
      end
    end
  endtask

  task automatic push(input placement_t p, input bit accept);
    check("cmd_ready", 80'(cmd_ready), 80'(accept));
    cmd_valid = 1'b1;
    {cmd_char, cmd_x, cmd_y, cmd_fg, cmd_bg} = p;
    if (accept) exp_q.push_back(p);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic bnd_tick(input bit exp_upd, input string name);
    pix_x = 12'd0;
    pix_y = 12'(V_ACTIVE);
    tick();
    pix_x = 12'd100;
    pix_y = 12'd10;
    check(name, 80'(frame_update), 80'(exp_upd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    placement_t a;
    tbl[0] = '{p: mk(20), dwell: 8'd2, frames: 2};
    tbl[1] = '{p: mk(21), dwell: 8'd0, frames: 1};
    tbl[2] = '{p: mk(22), dwell: 8'd1, frames: 1};
    tbl[3] = '{p: mk(23), dwell: 8'd5, frames: 5};
    tbl[4] = '{p: mk(24), dwell: 8'd1, frames: 1};

    // Reset state
    repeat (2) @(posedge pix_clk);
    #3 rst_n = 1'b1;
    tick();
    check("rst_out", cur, BlankPlacement);
    check("rst_count", 80'(fifo_count), 80'(0));
    check("rst_ready", 80'(cmd_ready), 80'(1));
    check("rst_update", 80'(frame_update), 80'(0));

    // First placement waits for the blank-start boundary
    a = '{chr: 8'h41, x: 12'd100, y: 12'd50, fg: 24'hFFFFFF, bg: 24'h000000};
    dwell_frames = 8'd1;
    push(a, 1'b1);
    repeat (3) tick();
    check("t1_blank_midframe", 80'(char_x), 80'(12'hFFF));
    pix_x = 12'd0; pix_y = 12'd479;
    tick();
    check("t1_line479", 80'(frame_update), 80'(0));
    pix_x = 12'd5; pix_y = 12'd480;
    tick();
    check("t1_x5", 80'(character), 80'(0));
    bnd_tick(1'b1, "t1_update");
    check("t1_char", 80'(character), 80'(8'h41));
    check("t1_x", 80'(char_x), 80'(12'd100));
    check("t1_count", 80'(fifo_count), 80'(0));
    tick();
    check("t1_update_width", 80'(frame_update), 80'(0));
    check("t1_hold", 80'(character), 80'(8'h41));

    // Dwell of 3 frames with two queued commands
    dwell_frames = 8'd3;
    push(mk(1), 1'b1);
    push(mk(2), 1'b1);
    check("t2_count2", 80'(fifo_count), 80'(2));
    bnd_tick(1'b1, "t2_load_b");
    check("t2_count1", 80'(fifo_count), 80'(1));
    bnd_tick(1'b0, "t2_dwell1");
    bnd_tick(1'b0, "t2_dwell2");
    check("t2_count1b", 80'(fifo_count), 80'(1));
    bnd_tick(1'b1, "t2_load_c");
    check("t2_count0", 80'(fifo_count), 80'(0));
    dwell_frames = 8'd1;
    bnd_tick(1'b0, "t2_drain1");
    bnd_tick(1'b0, "t2_drain2");
    bnd_tick(1'b0, "t2_hold_empty");
    check("t2_hold_char", 80'(character), 80'(mk(2).chr));

    // Dwell table: count boundaries until the follower loads
    dwell_frames = tbl[0].dwell;
    push(tbl[0].p, 1'b1);
    bnd_tick(1'b1, "tbl_first_load");
    for (int i = 0; i < 4; i++) begin
      int n;
      bit got;
      dwell_frames = tbl[i+1].dwell;
      push(tbl[i+1].p, 1'b1);
      n = 0;
      got = 1'b0;
      while (!got && n < 10) begin
        pix_x = 12'd0; pix_y = 12'(V_ACTIVE);
        tick();
        pix_x = 12'd100; pix_y = 12'd10;
        n++;
        got = frame_update;
      end
      check("tbl_frames", 80'(n), 80'(tbl[i].frames));
    end

    // Fill past full with no boundary
    dwell_frames = 8'd1;
    for (int i = 0; i < DEPTH + 2; i++) push(mk(30 + i), i < DEPTH);
    check("t3_count_full", 80'(fifo_count), 80'(DEPTH));
    check("t3_ready_full", 80'(cmd_ready), 80'(0));
    pix_x = 12'd0; pix_y = 12'(V_ACTIVE);
    cmd_valid = 1'b1;
    {cmd_char, cmd_x, cmd_y, cmd_fg, cmd_bg} = mk(50);
    tick();
    cmd_valid = 1'b0;
    pix_x = 12'd100; pix_y = 12'd10;
    check("t3_pop_full", 80'(frame_update), 80'(1));
    check("t3_count7", 80'(fifo_count), 80'(DEPTH - 1));
    check("t3_ready_after", 80'(cmd_ready), 80'(1));
    for (int i = 0; i < DEPTH - 1; i++) bnd_tick(1'b1, "t3_drain");
    check("t3_empty", 80'(fifo_count), 80'(0));

    // Push on the boundary cycle into an empty FIFO
    check("t4_ready", 80'(cmd_ready), 80'(1));
    pix_x = 12'd0; pix_y = 12'(V_ACTIVE);
    cmd_valid = 1'b1;
    {cmd_char, cmd_x, cmd_y, cmd_fg, cmd_bg} = mk(60);
    exp_q.push_back(mk(60));
    tick();
    cmd_valid = 1'b0;
    pix_x = 12'd100; pix_y = 12'd10;
    check("t4_no_pop", 80'(frame_update), 80'(0));
    check("t4_count", 80'(fifo_count), 80'(1));
    check("t4_old_char", 80'(character), 80'(mk(37).chr));
    bnd_tick(1'b1, "t4_load_next");

    // Clear with five queued entries
    for (int i = 0; i < 5; i++) push(mk(70 + i), 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_ready_low", 80'(cmd_ready), 80'(0));
    push(mk(80), 1'b0);
    check("t5_count5", 80'(fifo_count), 80'(5));
    repeat (2) tick();
    check("t5_ready_still_low", 80'(cmd_ready), 80'(0));
    bnd_tick(1'b1, "t5_flush_update");
    check("t5_blank", cur, BlankPlacement);
    check("t5_count0", 80'(fifo_count), 80'(0));
    exp_q.delete();
    tick();
    check("t5_ready_back", 80'(cmd_ready), 80'(1));
    bnd_tick(1'b0, "t5_blank_idle");

    // Asynchronous reset during SHOW with queued entries
    push(mk(90), 1'b1);
    bnd_tick(1'b1, "t6_show");
    for (int i = 1; i < 4; i++) push(mk(90 + i), 1'b1);
    check("t6_count3", 80'(fifo_count), 80'(3));
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_blank", cur, BlankPlacement);
    check("t6_async_count", 80'(fifo_count), 80'(0));
    exp_q.delete();
    repeat (2) tick();
    #3 rst_n = 1'b1;
    tick();
    check("t6_ready", 80'(cmd_ready), 80'(1));
    bnd_tick(1'b0, "t6_no_replay");
    check("t6_still_blank", 80'(char_x), 80'(12'hFFF));
    push(mk(95), 1'b1);
    bnd_tick(1'b1, "t6_new_load");
    check("sb_drained", 80'(exp_q.size()), 80'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
